// File: rtl/lot_pkg.sv
// Shared types for the parking-lot gate sensor decoder: FSM states and sensor codes.
// The optional debounce filter is enabled with LOT_DEBOUNCE_EN.
package lot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_AB,
    EX_A,
    RESYNC
  } gate_state_t;

  // Sensor codes are {a, b}; 1 means the beam is blocked.
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer for one gate photo-sensor, followed by a stability filter
// when LOT_DEBOUNCE_EN is defined (otherwise the synchronizer output is used as is).
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("sensor_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

`ifdef LOT_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clean_q;
  logic          clean_d;

  // The counter only advances while the synchronized input disagrees with the
  // filtered value; any agreeing sample restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (s2_q != clean_q) begin
      if (cnt_q >= LAST) begin
        clean_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;
`else
  assign clean = s2_q;
`endif

endmodule

// File: rtl/lot_gate_sensor.sv
// Decodes the outer (a) and inner (b) gate sensors into one-cycle inc/dec/err events.
// Define LOT_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter on each sensor.
module lot_gate_sensor
  import lot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec,
  output logic err,
  output logic busy
);

  logic        a_s;
  logic        b_s;
  logic [1:0]  ab;
  gate_state_t state_q;
  logic        inc_q;
  logic        dec_q;
  logic        err_q;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk  (clk),
    .reset(reset),
    .raw  (a),
    .clean(a_s)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk  (clk),
    .reset(reset),
    .raw  (b),
    .clean(b_s)
  );

  assign ab = {a_s, b_s};

  // Each state lists only the codes that move it; the code matching the state is a hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          case (ab)
            AB_A:    state_q <= EN_A;
            AB_B:    state_q <= EX_B;
            AB_BOTH: begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        EN_A: begin
          case (ab)
            AB_BOTH: state_q <= EN_AB;
            AB_NONE: state_q <= IDLE;
            AB_B:    begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        EN_AB: begin
          case (ab)
            AB_B:    state_q <= EN_B;
            AB_A:    state_q <= EN_A;
            AB_NONE: begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        EN_B: begin
          case (ab)
            AB_NONE: begin state_q <= IDLE; inc_q <= 1'b1; end
            AB_BOTH: state_q <= EN_AB;
            AB_A:    begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        EX_B: begin
          case (ab)
            AB_BOTH: state_q <= EX_AB;
            AB_NONE: state_q <= IDLE;
            AB_A:    begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        EX_AB: begin
          case (ab)
            AB_A:    state_q <= EX_A;
            AB_B:    state_q <= EX_B;
            AB_NONE: begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        EX_A: begin
          case (ab)
            AB_NONE: begin state_q <= IDLE; dec_q <= 1'b1; end
            AB_BOTH: state_q <= EX_AB;
            AB_B:    begin state_q <= RESYNC; err_q <= 1'b1; end
            default: ;
          endcase
        end
        RESYNC: begin
          if (ab == AB_NONE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_lot_gate_sensor.sv
// Self-checking bench for lot_gate_sensor; also exercises the filter when LOT_DEBOUNCE_EN is defined.
// The reference model treats a crossing as a walk around the 4-step cycle 00-10-11-01.
module tb_lot_gate_sensor;

  localparam int DB = 4;
`ifdef LOT_DEBOUNCE_EN
  localparam int PRELOAD = 4;
  localparam int HOLD    = DB + 1;
  localparam int EXTRA   = DB;
  localparam int GAP     = DB + 1;
`else
  localparam int PRELOAD = 3;
  localparam int HOLD    = 3;
  localparam int EXTRA   = 0;
  localparam int GAP     = 1;
`endif
  localparam int FLUSH = PRELOAD + EXTRA + 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic a     = 1'b0;
  logic b     = 1'b0;
  logic inc;
  logic dec;
  logic err;
  logic busy;

  lot_gate_sensor #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .inc  (inc),
    .dec  (dec),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];   // {inc, dec, err, busy} expected per sampled cycle
  logic [1:0] stim_q[$];
  int m_dir;              // 0 idle, 1 entering, 2 exiting, 3 waiting for clear
  int m_pos;
`ifdef LOT_DEBOUNCE_EN
  logic [1:0] raw_hist[$];
  logic [1:0] filt;
`endif

  function automatic int pos_of(int dir, logic [1:0] v);
    if (v == 2'b00) return 0;
    if (v == 2'b11) return 2;
    if (dir == 1) return (v == 2'b10) ? 1 : 3;
    return (v == 2'b01) ? 1 : 3;
  endfunction

  task automatic model_reset();
    m_dir = 0;
    m_pos = 0;
`ifdef LOT_DEBOUNCE_EN
    raw_hist.delete();
    filt = 2'b00;
`endif
    exp_q.delete();
    for (int i = 0; i < PRELOAD; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic model_step(input logic [1:0] raw, output logic [3:0] o);
    logic [1:0] v;
    logic i_e;
    logic d_e;
    logic e_e;
    int p;
    int d;
    i_e = 1'b0;
    d_e = 1'b0;
    e_e = 1'b0;
`ifdef LOT_DEBOUNCE_EN
    raw_hist.push_back(raw);
    if (raw_hist.size() > DB) void'(raw_hist.pop_front());
    if (raw_hist.size() == DB) begin
      for (int bi = 0; bi < 2; bi++) begin
        logic same;
        same = 1'b1;
        foreach (raw_hist[j]) if (raw_hist[j][bi] != raw[bi]) same = 1'b0;
        if (same) filt[bi] = raw[bi];
      end
    end
    v = filt;
`else
    v = raw;
`endif
    case (m_dir)
      0: begin
        if (v == 2'b10) begin m_dir = 1; m_pos = 1; end
        else if (v == 2'b01) begin m_dir = 2; m_pos = 1; end
        else if (v == 2'b11) begin m_dir = 3; e_e = 1'b1; end
      end
      3: if (v == 2'b00) m_dir = 0;
      default: begin
        p = pos_of(m_dir, v);
        d = (p - m_pos + 4) % 4;
        if (d == 2) begin
          m_dir = 3;
          e_e   = 1'b1;
        end else if (d != 0) begin
          if (p == 0) begin
            i_e   = (m_dir == 1) && (m_pos == 3);
            d_e   = (m_dir == 2) && (m_pos == 3);
            m_dir = 0;
          end
          m_pos = p;
        end
      end
    endcase
    o = {i_e, d_e, e_e, (m_dir != 0)};
  endtask

  // ---------------- driver ----------------
  task automatic push_stim(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  task automatic drive_cycle(input logic [1:0] v, output logic [3:0] obs, output logic [3:0] e);
    logic [3:0] o;
    @(negedge clk);
    obs = {inc, dec, err, busy};
    e   = exp_q.pop_front();
    {a, b} = v;
    model_step(v, o);
    exp_q.push_back(o);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    {a, b} = 2'b00;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] obs;
    logic [3:0] e;
    reset = 1'b0;
    {a, b} = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({inc, dec, err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000 (inc,dec,err,busy)", {inc, dec, err, busy});
    end
    reset = 1'b1;
    model_reset();
    push_stim(2'b00, 6);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_idle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
    end
  endtask

  task automatic test_entry();
    logic [3:0] obs;
    logic [3:0] e;
    int n_inc = 0;
    int n_other = 0;
    int inc_at = -1;
    int idx = 0;
    push_stim(2'b10, HOLD);
    push_stim(2'b11, HOLD);
    push_stim(2'b01, HOLD);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL entry_cycle %0d: got %b required %b (inc,dec,err,busy)", idx, obs, e);
      end
      if (obs[3] === 1'b1) begin n_inc++; inc_at = idx; end
      if (obs[2] === 1'b1 || obs[1] === 1'b1) n_other++;
      idx++;
    end
    checks++;
    if (n_inc != 1 || n_other != 0) begin
      errors++;
      $display("FAIL entry_pulses: got inc=%0d dec+err=%0d required inc=1 dec+err=0", n_inc, n_other);
    end
    checks++;
    if (inc_at != 3 * HOLD + 3 + EXTRA) begin
      errors++;
      $display("FAIL entry_latency: got inc at %0d required %0d", inc_at, 3 * HOLD + 3 + EXTRA);
    end
  endtask

  task automatic test_exit();
    logic [3:0] obs;
    logic [3:0] e;
    int n_inc = 0;
    int n_dec = 0;
    push_stim(2'b01, HOLD);
    push_stim(2'b11, HOLD);
    push_stim(2'b10, HOLD);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL exit_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      n_inc += int'(obs[3] === 1'b1);
      n_dec += int'(obs[2] === 1'b1);
    end
    checks++;
    if (n_dec != 1 || n_inc != 0) begin
      errors++;
      $display("FAIL exit_pulses: got dec=%0d inc=%0d required dec=1 inc=0", n_dec, n_inc);
    end
  endtask

  task automatic test_backout();
    logic [3:0] obs;
    logic [3:0] e;
    int n_pulse = 0;
    push_stim(2'b10, HOLD);
    push_stim(2'b11, HOLD);
    push_stim(2'b10, HOLD);
    push_stim(2'b00, FLUSH);
    push_stim(2'b01, HOLD);
    push_stim(2'b00, FLUSH);
    push_stim(2'b10, HOLD);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL backout_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      if (obs[3:1] !== 3'b000) n_pulse++;
    end
    checks++;
    if (n_pulse != 0 || obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL backout_result: got pulses=%0d busy=%b required pulses=0 busy=0", n_pulse, obs[0]);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] obs;
    logic [3:0] e;
    int n_err = 0;
    int n_busy = 0;
    push_stim(2'b11, HOLD + 5);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal_both_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      n_err  += int'(obs[1] === 1'b1);
      n_busy += int'(obs[0] === 1'b1);
    end
    checks++;
    if (n_err != 1 || n_busy < 5 || obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_both_result: got err=%0d busy_cycles=%0d final_busy=%b required err=1 busy_cycles>=5 final_busy=0",
               n_err, n_busy, obs[0]);
    end
    n_err = 0;
    push_stim(2'b10, HOLD);
    push_stim(2'b01, HOLD);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal_swap_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      n_err += int'(obs[1] === 1'b1);
    end
    checks++;
    if (n_err != 1) begin
      errors++;
      $display("FAIL illegal_swap_err: got err=%0d required 1", n_err);
    end
  endtask

  task automatic test_reset_mid_entry();
    logic [3:0] obs;
    logic [3:0] e;
    int n_pulse = 0;
    push_stim(2'b10, HOLD);
    push_stim(2'b11, 8);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midreset_pre: got %b required %b (inc,dec,err,busy)", obs, e);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b required 1", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({inc, dec, err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b required 0000 (inc,dec,err,busy)", {inc, dec, err, busy});
    end
    {a, b} = 2'b00;
    reset = 1'b1;
    model_reset();
    push_stim(2'b01, HOLD);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midreset_post: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      if (obs[3:2] !== 2'b00) n_pulse++;
    end
    checks++;
    if (n_pulse != 0) begin
      errors++;
      $display("FAIL midreset_no_count: got %0d inc/dec pulses required 0", n_pulse);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs;
    logic [3:0] e;
    int n_inc = 0;
    for (int k = 0; k < 3; k++) begin
      push_stim(2'b10, HOLD);
      push_stim(2'b11, HOLD);
      push_stim(2'b01, HOLD);
      push_stim(2'b00, (k == 2) ? FLUSH : GAP);
    end
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      n_inc += int'(obs[3] === 1'b1);
    end
    checks++;
    if (n_inc != 3) begin
      errors++;
      $display("FAIL b2b_count: got inc=%0d required 3", n_inc);
    end
  endtask

`ifdef LOT_DEBOUNCE_EN
  task automatic test_glitch();
    logic [3:0] obs;
    logic [3:0] e;
    int n_busy = 0;
    push_stim(2'b10, 2);
    push_stim(2'b00, 6);
    push_stim(2'b01, DB - 1);
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL glitch_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
      n_busy += int'(obs[0] !== 1'b0);
    end
    checks++;
    if (n_busy != 0) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles required 0", n_busy);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] obs;
    logic [3:0] e;
    logic [1:0] cur;
    logic [1:0] nxt;
    int n_bad = 0;
    cur = 2'b00;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 99) < 12) nxt = cur ^ 2'b11;
      else if ($urandom_range(0, 1) == 0) nxt = cur ^ 2'b01;
      else nxt = cur ^ 2'b10;
      push_stim(nxt, $urandom_range(1, HOLD + 2));
      cur = nxt;
    end
    push_stim(2'b00, FLUSH);
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), obs, e);
      checks++;
      if (obs !== e) begin
        errors++;
        n_bad++;
        if (n_bad <= 10) $display("FAIL random_cycle: got %b required %b (inc,dec,err,busy)", obs, e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_backout();
    test_illegal();
    test_reset_mid_entry();
    test_back_to_back();
`ifdef LOT_DEBOUNCE_EN
    test_glitch();
`endif
    apply_reset(2);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
